// File: rtl/periph_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : periph_bus_ctrl
// Description : Host request -> peripheral bus sequencer. Each accepted
//               request runs SETUP (1 cycle), STROBE (STROBE_CYCLES cycles)
//               and HOLD (1 cycle, rsp_valid pulse). All outputs registered.
//               Optional macro BUS_ERR_EN enables address range checking
//               against ADDR_MAX; out-of-range requests go straight to HOLD
//               with rsp_err=1 and no bus activity.
// Revision    : 1.0 - initial release
// ============================================================================
module periph_bus_ctrl #(
   parameter int unsigned STROBE_CYCLES = 4,
   parameter logic [3:0]  ADDR_MAX      = 4'hB
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_we,
   input  logic [3:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_err,
   output logic [3:0] addr,
   output logic       cs,
   output logic       rd,
   output logic       wr,
   output logic [7:0] wdata,
   input  logic [7:0] rdata
);

   // Strobe length, with 0 promoted to 1; counter counts down to 0.
   localparam logic [3:0] c_strobe_len = (STROBE_CYCLES == 0) ? 4'd1 : 4'(STROBE_CYCLES);
   localparam logic [3:0] c_cnt_last   = c_strobe_len - 4'd1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t     r_state;
   logic [3:0] r_cnt;
   logic       r_we;
   logic [3:0] r_addr_q;
   logic [7:0] r_wdata_q;
   logic       r_err;

   logic       r_req_ready;
   logic       r_rsp_valid;
   logic [7:0] r_rsp_rdata;
   logic       r_rsp_err;
   logic [3:0] r_addr;
   logic       r_cs;
   logic       r_rd;
   logic       r_wr;
   logic [7:0] r_wdata;

   state_t     w_state_nxt;
   logic [3:0] w_cnt_nxt;
   logic       w_we_nxt;
   logic [3:0] w_addr_q_nxt;
   logic [7:0] w_wdata_q_nxt;
   logic       w_err_nxt;
   logic       w_accept;
   logic       w_addr_over;
   logic       w_addr_bad;

   logic       w_ready_nxt;
   logic       w_rsp_valid_nxt;
   logic [7:0] w_rsp_rdata_nxt;
   logic       w_rsp_err_nxt;
   logic [3:0] w_addr_nxt;
   logic       w_cs_nxt;
   logic       w_rd_nxt;
   logic       w_wr_nxt;
   logic [7:0] w_wdata_nxt;

   assign w_accept    = req_valid & r_req_ready;
   assign w_addr_over = (req_addr > ADDR_MAX);

`ifdef BUS_ERR_EN
   assign w_addr_bad = w_addr_over;
`else
   // Range check disabled: every address runs the normal bus sequence.
   assign w_addr_bad = w_addr_over & 1'b0;
`endif

   // Next-state, request latching, strobe timing and next registered outputs.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_we_nxt        = r_we;
      w_addr_q_nxt    = r_addr_q;
      w_wdata_q_nxt   = r_wdata_q;
      w_err_nxt       = r_err;
      w_rsp_rdata_nxt = r_rsp_rdata;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_we_nxt      = req_we;
               w_addr_q_nxt  = req_addr;
               w_wdata_q_nxt = req_wdata;
               w_err_nxt     = w_addr_bad;
               w_state_nxt   = w_addr_bad ? HOLD : SETUP;
            end
         end
         SETUP: begin
            w_cnt_nxt   = c_cnt_last;
            w_state_nxt = STROBE;
         end
         STROBE: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = HOLD;
               // Last strobe cycle: capture peripheral read data.
               if (!r_we) begin
                  w_rsp_rdata_nxt = rdata;
               end
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         HOLD: begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Outputs are decoded from the state being entered so they register
      // in step with it.
      w_ready_nxt     = (w_state_nxt == IDLE);
      w_cs_nxt        = (w_state_nxt == SETUP) || (w_state_nxt == STROBE) ||
                        ((w_state_nxt == HOLD) && !w_err_nxt);
      w_rd_nxt        = (w_state_nxt == STROBE) && !w_we_nxt;
      w_wr_nxt        = (w_state_nxt == STROBE) && w_we_nxt;
      w_rsp_valid_nxt = (w_state_nxt == HOLD);
      w_rsp_err_nxt   = (w_state_nxt == HOLD) && w_err_nxt;
      w_addr_nxt      = w_cs_nxt ? w_addr_q_nxt : 4'd0;
      w_wdata_nxt     = w_cs_nxt ? w_wdata_q_nxt : 8'd0;
   end

   // State, strobe counter and latched request fields.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= 4'd0;
         r_we      <= 1'b0;
         r_addr_q  <= 4'd0;
         r_wdata_q <= 8'd0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_we      <= w_we_nxt;
         r_addr_q  <= w_addr_q_nxt;
         r_wdata_q <= w_wdata_q_nxt;
         r_err     <= w_err_nxt;
      end
   end

   // Registered host-side and peripheral-side outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 8'd0;
         r_rsp_err   <= 1'b0;
         r_addr      <= 4'd0;
         r_cs        <= 1'b0;
         r_rd        <= 1'b0;
         r_wr        <= 1'b0;
         r_wdata     <= 8'd0;
      end else begin
         r_req_ready <= w_ready_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_addr      <= w_addr_nxt;
         r_cs        <= w_cs_nxt;
         r_rd        <= w_rd_nxt;
         r_wr        <= w_wr_nxt;
         r_wdata     <= w_wdata_nxt;
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign addr      = r_addr;
   assign cs        = r_cs;
   assign rd        = r_rd;
   assign wr        = r_wr;
   assign wdata     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_periph_bus_ctrl
// Description : Self-checking bench for periph_bus_ctrl. A transaction-level
//               model tracks "cycles since accept" and derives every output
//               from it; directed transactions pin the model with literal
//               expectations, then randomized traffic with reset pulses runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_periph_bus_ctrl;

   localparam int         c_s        = 4;
   localparam logic [3:0] c_addr_max = 4'hB;

   logic       clk;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic       req_we;
   logic [3:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic [3:0] addr;
   logic       cs;
   logic       rd;
   logic       wr;
   logic [7:0] wdata;
   logic [7:0] rdata;

   int n_checks = 0;
   int n_errors = 0;

   periph_bus_ctrl #(
      .STROBE_CYCLES (c_s),
      .ADDR_MAX      (c_addr_max)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .addr      (addr),
      .cs        (cs),
      .rd        (rd),
      .wr        (wr),
      .wdata     (wdata),
      .rdata     (rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_k counts cycles since accept: 1 = setup, 2..S+1 = strobe, S+2 = hold.
   logic       m_busy;
   int         m_k;
   logic       m_err;
   logic       m_we;
   logic [3:0] m_addr;
   logic [7:0] m_wdata;
   logic [7:0] m_rdata;

   function automatic logic addr_bad(input logic [3:0] a);
`ifdef BUS_ERR_EN
      return a > c_addr_max;
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy  <= 1'b0;
         m_k     <= 0;
         m_err   <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= 4'd0;
         m_wdata <= 8'd0;
         m_rdata <= 8'd0;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy  <= 1'b1;
            m_we    <= req_we;
            m_addr  <= req_addr;
            m_wdata <= req_wdata;
            m_err   <= addr_bad(req_addr);
            m_k     <= addr_bad(req_addr) ? c_s + 2 : 1;
         end
      end else begin
         if (m_k == c_s + 1 && !m_we && !m_err) m_rdata <= rdata;
         if (m_k == c_s + 2) m_busy <= 1'b0;
         else m_k <= m_k + 1;
      end
   end

   // Compare every DUT output against the model once per cycle.
   always @(negedge clk) begin
      logic e_bus, e_strb;
      e_bus  = m_busy && !m_err;
      e_strb = e_bus && m_k >= 2 && m_k <= c_s + 1;
      check("req_ready", req_ready, !m_busy);
      check("cs",        cs,        e_bus);
      check("rd",        rd,        e_strb && !m_we);
      check("wr",        wr,        e_strb && m_we);
      check("rsp_valid", rsp_valid, m_busy && m_k == c_s + 2);
      check("rsp_err",   rsp_err,   m_busy && m_k == c_s + 2 && m_err);
      check("rsp_rdata", rsp_rdata, m_rdata);
      check("addr",      addr,      e_bus ? m_addr : 4'd0);
      check("wdata",     wdata,     e_bus ? m_wdata : 8'd0);
      check("rd_wr_excl", rd & wr, 1'b0);
   end

   // ---------------- directed helpers ----------------
   task automatic wait_ready();
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      check("wait_ready_timeout", req_ready, 1'b1);
   endtask

   // Issue one request and check cycles 1..7 after accept with literal values
   // for STROBE_CYCLES=4: cs 1..6, strobe 2..5, rsp_valid at 6.
   task automatic do_txn(input logic we, input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd);
      wait_ready();
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~d;
      for (int n = 1; n <= 7; n++) begin
         check("lit_cs",        cs,        n <= 6);
         check("lit_wr",        wr,        we && n >= 2 && n <= 5);
         check("lit_rd",        rd,        !we && n >= 2 && n <= 5);
         check("lit_rsp_valid", rsp_valid, n == 6);
         if (n == 3) check("lit_addr", addr, a);
         if (n == 3 && we) check("lit_wdata", wdata, d);
         if (n == 6) begin
            check("lit_rsp_err",   rsp_err,   1'b0);
            check("lit_rsp_rdata", rsp_rdata, exp_rd);
         end
         @(negedge clk);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t1, t2;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 4'd0;
      req_wdata = 8'd0; rdata = 8'h00;
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_cs",        cs,        1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_rdata", rsp_rdata, 8'h00);
      check("rst_wdata",     wdata,     8'h00);

      // Write addr 2 data A5; then read addr 8 with peripheral data 3C.
      do_txn(1'b1, 4'h2, 8'hA5, 8'h00);
      rdata = 8'h3C;
      do_txn(1'b0, 4'h8, 8'h00, 8'h3C);
      // A write leaves the previous read data in place.
      do_txn(1'b1, 4'h5, 8'h11, 8'h3C);

      // Back-to-back: req_valid held high, addresses 0 then 4.
      wait_ready();
      t1 = -1; t2 = -1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h0;
      for (int t = 0; t < 40 && t2 < 0; t++) begin
         if (t1 >= 0 && t == t1 + 1) req_addr = 4'h4;
         if (req_ready && req_valid) begin
            if (t1 < 0) t1 = t;
            else t2 = t;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("b2b_interval", t2 - t1, 7);

      // Reset during the second strobe cycle of a write.
      wait_ready();
      req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h3; req_wdata = 8'h5A;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_wr", wr, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("async_wr_drop",  wr,        1'b0);
      check("async_cs_drop",  cs,        1'b0);
      check("async_no_valid", rsp_valid, 1'b0);
      @(negedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("no_rsp_after_abort", rsp_valid, 1'b0);
      end
      rdata = 8'hC3;
      do_txn(1'b0, 4'h1, 8'h00, 8'hC3);

      // Address above ADDR_MAX.
      wait_ready();
`ifdef BUS_ERR_EN
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'hE;
      @(negedge clk);
      req_valid = 1'b0;
      check("err_rsp_valid", rsp_valid, 1'b1);
      check("err_rsp_err",   rsp_err,   1'b1);
      check("err_cs",        cs,        1'b0);
      check("err_rdata_kept", rsp_rdata, 8'hC3);
      @(negedge clk);
      check("err_back_idle", req_ready, 1'b1);
`else
      rdata = 8'h77;
      do_txn(1'b0, 4'hE, 8'h00, 8'h77);
`endif

      // Randomized traffic with occasional reset pulses.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         req_valid = ($urandom_range(0, 2) != 0);
         req_we    = 1'($urandom);
         req_addr  = 4'($urandom);
         req_wdata = 8'($urandom);
         rdata     = 8'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk);
            #2 rst = 1'b0;
         end
      end
      req_valid = 1'b0;
      repeat (10) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
